// File: rtl/adt_tx_frame_builder_pkg.sv
// ----------------------------------------------------------------------------
// adt_tx_frame_builder_pkg
// Shared definitions for the ADT UART terminal TX frame builder: frame
// delimiters, frame/payload lengths, default timing constants and the
// frame-builder FSM state encoding.
// ----------------------------------------------------------------------------
package adt_tx_frame_builder_pkg;

    localparam logic [7:0]  ADT_SOF_L     = 8'hEB;
    localparam logic [7:0]  ADT_SOF_H     = 8'h90;
    localparam logic [15:0] ADT_FRAME_LEN = 16'd66;
    localparam logic [6:0]  ADT_PAY_LEN   = 7'd61;
    localparam logic [31:0] ADT_T_PERIOD  = 32'd3_500_000;  // 70 ms at 50 MHz
    localparam logic [7:0]  ADT_T_ACK_TO  = 8'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_FETCH   = 3'd2,
        ST_CSUM    = 3'd3,
        ST_START   = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_WAIT_LO = 3'd6
    } adt_state_t;

endpackage

// File: rtl/adt_tx_frame_builder_period_timer.sv
// ----------------------------------------------------------------------------
// adt_period_timer
// Free-running period timer. Counts while i_enable is high and asserts o_tick
// during the last count of each period, then reloads to 0. i_enable low holds
// the count at 0.
// Ports:
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   i_enable  in  1 = count
//   o_tick    out one-cycle tick at count T_PERIOD-1
// ----------------------------------------------------------------------------
module adt_period_timer
    import adt_tx_frame_builder_pkg::*;
#(
    parameter logic [31:0] T_PERIOD = ADT_T_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam logic [31:0] LAST = T_PERIOD - 32'd1;

    logic [31:0] r_count;

    assign o_tick = i_enable && (r_count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 32'd0;
        end else if (!i_enable || (r_count == LAST)) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule

// File: rtl/adt_tx_frame_builder.sv
// ----------------------------------------------------------------------------
// adt_tx_frame_builder
// Assembles a 66-byte TX frame (SOF_L, SOF_H, seq, length, 61 payload bytes,
// checksum) into the terminal TX RAM as 66 back-to-back writes, then pulses
// tx_frame_start and waits for the terminal to go busy and idle again.
// Frames are triggered by the period timer or by send_req (both gated by
// enable). A trigger that cannot start immediately pends; a second one while
// pending is dropped with an overrun pulse.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                timer run / trigger accept
//   send_req              one-cycle manual trigger
//   pay_rd, pay_addr      payload read strobe and index (0..60)
//   pay_data              payload byte, valid the cycle after pay_rd
//   tx_busy               terminal busy flag
//   data_ram, addr_ram,
//   wr_ram                TX RAM write port (zero when not writing)
//   tx_frame_start        one-cycle pulse, frame complete in RAM
//   building              FSM not idle
//   frame_seq             sequence number for the next frame
//   overrun               one-cycle pulse, trigger dropped
//   ack_err               one-cycle pulse, tx_busy did not rise in time
// ----------------------------------------------------------------------------
module adt_tx_frame_builder
    import adt_tx_frame_builder_pkg::*;
#(
    parameter logic [7:0]  T_SOF_L     = ADT_SOF_L,
    parameter logic [7:0]  T_SOF_H     = ADT_SOF_H,
    parameter logic [15:0] T_FRAME_LEN = ADT_FRAME_LEN,
    parameter logic [6:0]  PAY_LEN     = ADT_PAY_LEN,
    parameter logic [31:0] T_PERIOD    = ADT_T_PERIOD,
    parameter logic [7:0]  T_ACK_TO    = ADT_T_ACK_TO
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        send_req,
    output logic        pay_rd,
    output logic [5:0]  pay_addr,
    input  logic [7:0]  pay_data,
    input  logic        tx_busy,
    output logic [7:0]  data_ram,
    output logic [15:0] addr_ram,
    output logic        wr_ram,
    output logic        tx_frame_start,
    output logic        building,
    output logic [7:0]  frame_seq,
    output logic        overrun,
    output logic        ack_err
);

    localparam logic [6:0] PAY_LAST    = PAY_LEN - 7'd1;
    localparam logic [6:0] PAY_RD_LAST = PAY_LEN - 7'd2;
    localparam logic [7:0] ACK_LAST    = T_ACK_TO - 8'd1;

    adt_state_t  r_state;
    logic [6:0]  r_cnt;
    logic [7:0]  r_ack_cnt;
    logic [7:0]  r_csum;
    logic [7:0]  r_data;
    logic [6:0]  r_addr;
    logic        r_wr;
    logic        r_fetch;
    logic        r_pay_rd;
    logic [5:0]  r_pay_addr;
    logic        r_start;
    logic        r_overrun;
    logic        r_ack_err;
    logic        r_pending;
    logic [7:0]  r_seq;

    logic        w_tick;
    logic        w_trig;
    logic        w_start;
    logic [7:0]  w_wr_data;

    adt_period_timer #(
        .T_PERIOD (T_PERIOD)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [7:0] seq);
        case (idx)
            2'd0:    hdr_byte = T_SOF_L;
            2'd1:    hdr_byte = T_SOF_H;
            2'd2:    hdr_byte = seq;
            default: hdr_byte = T_FRAME_LEN[7:0];
        endcase
    endfunction

    // tick and send_req together collapse into one trigger
    assign w_trig  = enable & (w_tick | send_req);
    assign w_start = (r_state == ST_IDLE) && !tx_busy && (w_trig || (r_pending && enable));

    // Payload bytes arrive the cycle they are written, so during FETCH the
    // RAM data is a pass-through of pay_data; r_data is 0 in that phase.
    assign w_wr_data = r_fetch ? pay_data : r_data;

    assign data_ram       = w_wr_data;
    assign addr_ram       = {9'd0, r_addr};
    assign wr_ram         = r_wr;
    assign pay_rd         = r_pay_rd;
    assign pay_addr       = r_pay_addr;
    assign tx_frame_start = r_start;
    assign building       = (r_state != ST_IDLE);
    assign frame_seq      = r_seq;
    assign overrun        = r_overrun;
    assign ack_err        = r_ack_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 7'd0;
            r_ack_cnt  <= 8'd0;
            r_csum     <= 8'd0;
            r_data     <= 8'd0;
            r_addr     <= 7'd0;
            r_wr       <= 1'b0;
            r_fetch    <= 1'b0;
            r_pay_rd   <= 1'b0;
            r_pay_addr <= 6'd0;
            r_start    <= 1'b0;
            r_overrun  <= 1'b0;
            r_ack_err  <= 1'b0;
            r_pending  <= 1'b0;
            r_seq      <= 8'd0;
        end else begin
            r_start    <= 1'b0;
            r_overrun  <= 1'b0;
            r_ack_err  <= 1'b0;
            r_pay_rd   <= 1'b0;
            r_pay_addr <= 6'd0;

            // running checksum of every byte presented to the RAM
            if (r_wr) begin
                r_csum <= r_csum + w_wr_data;
            end

            if (!enable) begin
                r_pending <= 1'b0;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_trig) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_HDR;
                        r_cnt   <= 7'd0;
                        r_wr    <= 1'b1;
                        r_addr  <= 7'd0;
                        r_data  <= T_SOF_L;
                        r_csum  <= 8'd0;
                    end
                end
                ST_HDR: begin
                    if (r_cnt[1:0] == 2'd3) begin
                        r_state    <= ST_FETCH;
                        r_cnt      <= 7'd0;
                        r_addr     <= r_addr + 7'd1;
                        r_data     <= 8'd0;
                        r_fetch    <= 1'b1;
                        r_pay_rd   <= 1'b1;
                        r_pay_addr <= 6'd1;
                    end else begin
                        r_cnt  <= r_cnt + 7'd1;
                        r_addr <= r_addr + 7'd1;
                        r_data <= hdr_byte(r_cnt[1:0] + 2'd1, r_seq);
                        // first payload read overlaps the length byte write
                        if (r_cnt[1:0] == 2'd2) begin
                            r_pay_rd   <= 1'b1;
                            r_pay_addr <= 6'd0;
                        end
                    end
                end
                ST_FETCH: begin
                    r_addr <= r_addr + 7'd1;
                    if (r_cnt == PAY_LAST) begin
                        r_state <= ST_CSUM;
                        r_fetch <= 1'b0;
                        r_data  <= r_csum + pay_data;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                        // read k+2 is issued while byte k+1 is being written
                        if (r_cnt < PAY_RD_LAST) begin
                            r_pay_rd   <= 1'b1;
                            r_pay_addr <= r_cnt[5:0] + 6'd2;
                        end
                    end
                end
                ST_CSUM: begin
                    r_state <= ST_START;
                    r_wr    <= 1'b0;
                    r_addr  <= 7'd0;
                    r_data  <= 8'd0;
                    r_start <= 1'b1;
                end
                ST_START: begin
                    r_state   <= ST_WAIT_HI;
                    r_seq     <= r_seq + 8'd1;
                    r_ack_cnt <= 8'd1;
                end
                ST_WAIT_HI: begin
                    // timeout measured from the tx_frame_start cycle
                    if (tx_busy) begin
                        r_state <= ST_WAIT_LO;
                    end else if (r_ack_cnt == ACK_LAST) begin
                        r_ack_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 8'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
